// File: rtl/mem_arb_pkg.sv
// Shared types and MMIO address map for the memory arbiter.
// Response-owner states and the decoded peripheral addresses.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_RESP = 2'd1,
    ST_LS_RESP = 2'd2
  } state_t;

  localparam logic [9:0] ADDR_SEG0 = 10'h3FF;
  localparam logic [9:0] ADDR_SEG1 = 10'h3FE;
  localparam logic [9:0] ADDR_BTN  = 10'h3EF;

endpackage

// File: rtl/mem_arbiter_btn_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Output follows the input after two rising edges of clk.
module btn_sync #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] meta_reg;
  logic [width-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between fetch and
// load-store, with seven-segment and push-button MMIO on the load-store side.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [addr_width-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [data_width-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [addr_width-1:0] ls_addr,
  input  logic [data_width-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [data_width-1:0] ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  input  logic [data_width-1:0] mem_rdata,
  input  logic [3:0]            btn_in,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1
);

  localparam logic [addr_width-1:0] SEG0_A = addr_width'(ADDR_SEG0);
  localparam logic [addr_width-1:0] SEG1_A = addr_width'(ADDR_SEG1);
  localparam logic [addr_width-1:0] BTN_A  = addr_width'(ADDR_BTN);

  state_t          state_reg, state_next;
  logic            ls_prio_reg, ls_prio_next;
  logic [7:0]      seg0_reg, seg1_reg;
  logic            btn_rd_reg;
  logic [3:0]      btn_data_reg;
  logic [3:0]      btn_synced;
  logic [data_width-1:0] if_hold_reg, ls_hold_reg;
  logic            seg0_hit, seg1_hit, btn_hit, ls_mmio;

  btn_sync #(.width(4)) u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_in),
    .dout (btn_synced)
  );

  // ls_prio_reg set means LS wins the next contended cycle.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req && ls_req) begin
        if (ls_prio_reg) ls_gnt = 1'b1;
        else             if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign seg0_hit = ls_we && (ls_addr == SEG0_A);
  assign seg1_hit = ls_we && (ls_addr == SEG1_A);
  assign btn_hit  = !ls_we && (ls_addr == BTN_A);
  assign ls_mmio  = seg0_hit || seg1_hit || btn_hit;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (ls_gnt && !ls_mmio) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  // Next state depends only on this cycle's grant, so responses pipeline.
  always_comb begin
    state_next   = ST_IDLE;
    ls_prio_next = ls_prio_reg;
    if (if_gnt) begin
      state_next   = ST_IF_RESP;
      ls_prio_next = 1'b1;
    end else if (ls_gnt) begin
      ls_prio_next = 1'b0;
      if (!ls_we) state_next = ST_LS_RESP;
    end
  end

  assign if_rvalid = !rst && (state_reg == ST_IF_RESP);
  assign ls_rvalid = !rst && (state_reg == ST_LS_RESP);

  always_comb begin
    if_rdata = '0;
    ls_rdata = '0;
    if (!rst) begin
      if_rdata = if_rvalid ? mem_rdata : if_hold_reg;
      if (ls_rvalid) begin
        ls_rdata = btn_rd_reg ? {{(data_width-4){1'b0}}, btn_data_reg} : mem_rdata;
      end else begin
        ls_rdata = ls_hold_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ls_prio_reg  <= 1'b1;
      seg0_reg     <= '0;
      seg1_reg     <= '0;
      btn_rd_reg   <= 1'b0;
      btn_data_reg <= '0;
      if_hold_reg  <= '0;
      ls_hold_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ls_prio_reg <= ls_prio_next;
      btn_rd_reg  <= ls_gnt && btn_hit;
      if (ls_gnt && btn_hit)  btn_data_reg <= btn_synced;
      if (ls_gnt && seg0_hit) seg0_reg <= ls_wdata[7:0];
      if (ls_gnt && seg1_hit) seg1_reg <= ls_wdata[7:0];
      if (if_rvalid) if_hold_reg <= if_rdata;
      if (ls_rvalid) ls_hold_reg <= ls_rdata;
    end
  end

  assign seg0 = seg0_reg;
  assign seg1 = seg1_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter addr_width, default 10, word address width of data memory and MMIO space.
REQ-002 Parameter data_width, default 32, data word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req / if_addr  in  1 / addr_width  instruction-fetch read request; addr held until if_gnt.
REQ-006 if_gnt / if_rvalid / if_rdata  out  1 / 1 / data_width  fetch grant; read data valid one cycle after grant.
REQ-007 ls_req / ls_we / ls_addr / ls_wdata  in  1 / 1 / addr_width / data_width  load-store request; inputs held until ls_gnt.
REQ-008 ls_gnt / ls_rvalid / ls_rdata  out  1 / 1 / data_width  load-store grant; load data valid one cycle after grant.
REQ-009 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / addr_width / data_width  synchronous RAM port, one access per cycle.
REQ-010 mem_rdata  in  data_width  RAM read data, valid the cycle after mem_en with mem_we=0.
REQ-011 btn_in  in  4  asynchronous push-button array.
REQ-012 seg0 / seg1  out  8 / 8  seven-segment display registers.

Function
REQ-013 Grant combinational in cycle N from sampled requests; granted access drives memory or MMIO port in cycle N.
REQ-014 At most one grant per cycle; if_gnt and ls_gnt never both 1.
REQ-015 Single requester: granted the same cycle req is seen, back-to-back every cycle allowed.
REQ-016 Both requesting: round-robin; grant the port not granted most recently; after reset LS has priority.
REQ-017 Read response: rvalid on the owning port exactly cycle N+1, 1 cycle wide, rdata valid with it.
REQ-018 Writes produce no rvalid; ls_gnt is the write acknowledge.
REQ-019 FSM states ST_IDLE, ST_IF_RESP, ST_LS_RESP track owner of the response due next cycle; next state from current grant (read) or ST_IDLE (write/no grant), regardless of current state (pipelined).
REQ-020 LS write to 10'h3FF loads seg0 <= ls_wdata[7:0]; to 10'h3FE loads seg1; mem_en stays 0.
REQ-021 LS read of 10'h3EF: mem_en stays 0; ls_rdata next cycle = synchronized btn_in zero-extended.
REQ-022 LS read/write of all other addresses forwarded to RAM; fetch never MMIO-decoded, always RAM read.
REQ-023 if_rdata / ls_rdata hold last value when rvalid is 0.
REQ-024 btn_in passes a two-flop synchronizer; sample latency 2 cycles.

Reset
REQ-025 During rst: gnt, rvalid, mem_en, mem_we = 0; rdata, seg0, seg1 = 0; state ST_IDLE; round-robin pointer favours LS; synchronizer flops 0.
REQ-026 rst asserted with a response outstanding drops it; no rvalid in the cycle after reset deasserts.
REQ-027 No grants issued in a cycle with rst=1.

Structure
REQ-028 Package mem_arb_pkg holds the state enum and MMIO constants (ADDR_SEG0=10'h3FF, ADDR_SEG1=10'h3FE, ADDR_BTN=10'h3EF).
REQ-029 Sub-module btn_sync (parameterized width two-flop synchronizer) instantiated once; all else in mem_arbiter.

Verification
REQ-030 Reset then if_req only, addr 10'h010, RAM holds 32'hDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=32'hDEADBEEF.
REQ-031 if_req and ls_req together for 4 cycles from reset -> grants LS,IF,LS,IF; each read's rvalid lands on its own port one cycle later.
REQ-032 LS write 32'h0000005A to 10'h3FF, then 32'h000000C3 to 10'h3FE -> seg0=8'h5A, seg1=8'hC3, mem_en=0 both cycles.
REQ-033 btn_in=4'b1010 held 3 cycles, then LS read 10'h3EF -> ls_rdata=32'h0000000A with ls_rvalid, mem_en=0.
REQ-034 LS read granted, rst asserted next cycle -> no ls_rvalid, all outputs 0, first post-reset contention grants LS.
REQ-035 Back-to-back LS write 10'h020 then read 10'h020 -> read returns written data, ls_rvalid only for the read.
